// File: rtl/glyph_tile_writer_if.sv
// glyph_tile_writer_if: start/stream handshake and BRAM write port bundle (master = loader/tb, slave = writer)
interface glyph_tile_writer_if #(parameter int AW = 17);
  logic          start_in;
  logic [4:0]    letter_in;
  logic [7:0]    pix_data_in;
  logic          pix_valid_in;
  logic          pix_ready_out;
  logic [AW-1:0] bram_addr_out;
  logic [7:0]    bram_din_out;
  logic          bram_we_out;
  logic          busy_out;
  logic          done_out;
  logic          error_out;
  modport master (
    output start_in, letter_in, pix_data_in, pix_valid_in,
    input  pix_ready_out, bram_addr_out, bram_din_out, bram_we_out, busy_out, done_out, error_out
  );
  modport slave (
    input  start_in, letter_in, pix_data_in, pix_valid_in,
    output pix_ready_out, bram_addr_out, bram_din_out, bram_we_out, busy_out, done_out, error_out
  );
endinterface

// File: rtl/glyph_tile_writer.sv
// glyph_tile_writer: streams one TILE_W x TILE_H letter tile into the atlas BRAM; ports: pixel_clk_in, rst_n_in, bus (start/letter, pixel valid/ready, BRAM write, busy/done/error)
module glyph_tile_writer #(
  parameter int WIDTH         = 256,
  parameter int HEIGHT        = 512,
  parameter int TILE_W        = 38,
  parameter int TILE_H        = 45,
  parameter int TILES_PER_ROW = 6
) (
  input logic               pixel_clk_in,
  input logic               rst_n_in,
  glyph_tile_writer_if.slave bus
);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);
  typedef enum logic [1:0] {IDLE, BASE, STREAM} state_t;
  state_t        state_q;
  logic [4:0]    letter_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] row_q;
  logic [AW-1:0] idx, base_d;
  logic [AW-1:0] addr_q;
  logic [7:0]    din_q;
  logic          ready_q, we_q, busy_q, done_q, error_q;
  logic          hs, x_last, y_last, letter_ok;
  always_comb begin
    idx    = AW'(letter_q) - AW'(1);
    base_d = (idx / AW'(TILES_PER_ROW)) * AW'(TILE_H * WIDTH) + (idx % AW'(TILES_PER_ROW)) * AW'(TILE_W);
  end
  assign hs        = bus.pix_valid_in & ready_q;
  assign x_last    = x_q == XW'(TILE_W - 1);
  assign y_last    = y_q == YW'(TILE_H - 1);
  assign letter_ok = bus.letter_in != 5'd0 && bus.letter_in <= 5'd26;
  // row_q starts at the tile base and steps by WIDTH per tile row, so the pixel address is just row_q + x
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      letter_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start_in) begin
          if (letter_ok) begin
            letter_q <= bus.letter_in;
            busy_q   <= 1'b1;
            state_q  <= BASE;
          end else error_q <= 1'b1;
        end
        BASE: begin
          row_q   <= base_d;
          x_q     <= '0;
          y_q     <= '0;
          ready_q <= 1'b1;
          state_q <= STREAM;
        end
        STREAM: if (hs) begin
          we_q   <= 1'b1;
          addr_q <= row_q + AW'(x_q);
          din_q  <= bus.pix_data_in;
          if (x_last) begin
            x_q   <= '0;
            y_q   <= y_q + YW'(1);
            row_q <= row_q + AW'(WIDTH);
            if (y_last) begin
              state_q <= IDLE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else x_q <= x_q + XW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.pix_ready_out = ready_q;
  assign bus.bram_we_out   = we_q;
  assign bus.bram_addr_out = addr_q;
  assign bus.bram_din_out  = din_q;
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.error_out     = error_q;
endmodule

// File: tb/tb_glyph_tile_writer.sv
// tb_glyph_tile_writer: randomized tile loads checked against an arithmetic atlas-layout model
module tb_glyph_tile_writer;
  localparam int W = 256, TW = 38, TH = 45, TPR = 6, N = TW * TH;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  glyph_tile_writer_if #(.AW(17)) bus();
  glyph_tile_writer dut (.pixel_clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  int vectors = 0, miscompares = 0;
  logic [16:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  sd[$];
  int done_cnt, done_we, err_cnt, busy_cnt, bad_we;
  logic [16:0] done_addr;
  logic busy_mid;
  bit mon_hs;
  always @(posedge clk) begin
    mon_hs = bus.pix_valid_in & bus.pix_ready_out;
    #1;
    if (rst_n) begin
      if (bus.bram_we_out !== mon_hs) bad_we++;
      if (bus.bram_we_out) begin
        wa.push_back(bus.bram_addr_out);
        wd.push_back(bus.bram_din_out);
      end
      if (bus.done_out) begin
        done_cnt++;
        done_we   = bus.bram_we_out;
        done_addr = bus.bram_addr_out;
      end
      if (bus.error_out) err_cnt++;
      if (bus.busy_out) busy_cnt++;
    end
  end
  function automatic int exp_addr(int l, int i);
    return ((l - 1) / TPR) * TH * W + ((l - 1) % TPR) * TW + (i / TW) * W + i % TW;
  endfunction
  function automatic int seq_err(int l);
    int e = (wa.size() != sd.size()) ? 1 : 0;
    for (int i = 0; i < wa.size() && i < sd.size(); i++)
      if (int'(wa[i]) != exp_addr(l, i) || wd[i] !== sd[i]) e++;
    return e;
  endfunction
  task automatic clear();
    wa.delete(); wd.delete(); sd.delete();
    done_cnt = 0; done_we = 0; err_cnt = 0; busy_cnt = 0; bad_we = 0; busy_mid = 1'b0;
  endtask
  task automatic run(input int l, input int pct, input int nb, input bit ramp, input int stray_at, output bit to);
    int beats = 0, cyc = 0;
    bit strayed = 0;
    logic [7:0] d;
    bus.start_in = 1'b1; bus.letter_in = 5'(l);
    @(negedge clk);
    bus.start_in = 1'b0;
    while (beats < nb && cyc < 20000) begin
      bus.start_in = 1'b0;
      if (stray_at >= 0 && beats >= stray_at && !strayed) begin
        bus.start_in = 1'b1; bus.letter_in = 5'd3; strayed = 1;
      end
      d = ramp ? 8'(beats) : 8'($urandom);
      bus.pix_valid_in = $urandom_range(99) < pct;
      bus.pix_data_in = d;
      if (beats == 100) busy_mid = bus.busy_out;
      if (bus.pix_valid_in && bus.pix_ready_out) begin
        sd.push_back(d);
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.pix_valid_in = 1'b0; bus.start_in = 1'b0;
    to = beats < nb;
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    vectors++;
    if ({bus.pix_ready_out, bus.bram_we_out, bus.bram_addr_out, bus.bram_din_out, bus.busy_out, bus.done_out, bus.error_out} !== 30'd0) begin
      miscompares++; $display("FAIL reset_outputs got we=%b addr=%0d busy=%b", bus.bram_we_out, bus.bram_addr_out, bus.busy_out);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if ({bus.pix_ready_out, bus.bram_we_out, bus.busy_out, bus.done_out, bus.error_out} !== 5'd0) begin
        miscompares++; $display("FAIL idle_quiet got ready=%b we=%b busy=%b want all 0", bus.pix_ready_out, bus.bram_we_out, bus.busy_out);
      end
    end
  endtask
  task automatic test_letter1();
    bit to;
    clear();
    run(1, 100, N, 1, -1, to);
    vectors++; if (to) begin miscompares++; $display("FAIL l1_timeout got stalled want %0d beats", N); end
    vectors++; if (wa.size() != N) begin miscompares++; $display("FAIL l1_count got %0d want %0d", wa.size(), N); end
    vectors++; if (wa.size() < N || {wa[0], wd[0]} !== {17'd0, 8'd0}) begin miscompares++; $display("FAIL l1_first got size %0d want addr 0 data 0", wa.size()); end
    vectors++; if (wa.size() < N || {wa[38], wd[38]} !== {17'd256, 8'd38}) begin miscompares++; $display("FAIL l1_row1 got size %0d want addr 256 data 38", wa.size()); end
    vectors++; if (wa.size() < N || {wa[N-1], wd[N-1]} !== {17'd11301, 8'd173}) begin miscompares++; $display("FAIL l1_last got size %0d want addr 11301 data 173", wa.size()); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL l1_done_cnt got %0d want 1", done_cnt); end
    vectors++; if (done_we != 1 || done_addr !== 17'd11301) begin miscompares++; $display("FAIL l1_done_with_last got we=%0d addr=%0d want 1/11301", done_we, done_addr); end
    vectors++; if (busy_mid !== 1'b1) begin miscompares++; $display("FAIL l1_busy_mid got %b want 1", busy_mid); end
    vectors++; if ({bus.busy_out, bus.pix_ready_out} !== 2'b00) begin miscompares++; $display("FAIL l1_after_done got busy=%b ready=%b want 0", bus.busy_out, bus.pix_ready_out); end
    vectors++; if (seq_err(1) != 0) begin miscompares++; $display("FAIL l1_sequence got %0d bad writes want 0", seq_err(1)); end
    bus.pix_valid_in = 1'b1;
    repeat (5) @(negedge clk);
    bus.pix_valid_in = 1'b0;
    vectors++; if (wa.size() != N || bad_we != 0) begin miscompares++; $display("FAIL l1_surplus got %0d writes bad_we=%0d want %0d/0", wa.size(), bad_we, N); end
  endtask
  task automatic test_back_to_back();
    bit to;
    int n6, e6;
    logic [16:0] f6, l6;
    clear();
    run(6, 100, N, 0, -1, to);
    n6 = wa.size(); e6 = seq_err(6) + (to ? 1 : 0);
    f6 = n6 > 0 ? wa[0] : 17'h1ffff; l6 = n6 > 0 ? wa[n6-1] : 17'h1ffff;
    clear();
    run(7, 100, N, 0, -1, to);
    vectors++; if (f6 !== 17'd190 || l6 !== 17'd11491) begin miscompares++; $display("FAIL l6_bounds got %0d..%0d want 190..11491", f6, l6); end
    vectors++; if (n6 != N || e6 != 0) begin miscompares++; $display("FAIL l6_sequence got n=%0d err=%0d want %0d/0", n6, e6, N); end
    vectors++; if (wa.size() == 0 || wa[0] !== 17'd11520) begin miscompares++; $display("FAIL l7_first got size %0d want addr 11520", wa.size()); end
    vectors++; if (to || wa.size() != N || seq_err(7) != 0) begin miscompares++; $display("FAIL l7_sequence got n=%0d err=%0d want %0d/0", wa.size(), seq_err(7), N); end
    clear();
    run(26, 100, N, 0, -1, to);
    vectors++; if (wa.size() == 0 || wa[0] !== 17'd46118) begin miscompares++; $display("FAIL l26_first got size %0d want addr 46118", wa.size()); end
    vectors++; if (to || wa.size() != N || seq_err(26) != 0) begin miscompares++; $display("FAIL l26_sequence got n=%0d err=%0d want %0d/0", wa.size(), seq_err(26), N); end
  endtask
  task automatic test_valid_toggle();
    bit to;
    clear();
    run(7, 50, N, 0, -1, to);
    vectors++; if (to || wa.size() != N) begin miscompares++; $display("FAIL toggle_count got %0d want %0d", wa.size(), N); end
    vectors++; if (seq_err(7) != 0) begin miscompares++; $display("FAIL toggle_sequence got %0d bad writes want 0", seq_err(7)); end
    vectors++; if (bad_we != 0) begin miscompares++; $display("FAIL toggle_we_timing got %0d stray/missing writes want 0", bad_we); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL toggle_done got %0d want 1", done_cnt); end
  endtask
  task automatic test_error();
    logic [4:0] bad[2] = '{5'd0, 5'd27};
    clear();
    for (int k = 0; k < 2; k++) begin
      bus.start_in = 1'b1; bus.letter_in = bad[k];
      @(negedge clk);
      bus.start_in = 1'b0;
      repeat (4) @(negedge clk);
      vectors++; if (err_cnt != k + 1) begin miscompares++; $display("FAIL error_pulse letter %0d got %0d pulse cycles want %0d", bad[k], err_cnt, k + 1); end
    end
    vectors++; if (busy_cnt != 0 || wa.size() != 0) begin miscompares++; $display("FAIL error_quiet got busy=%0d writes=%0d want 0/0", busy_cnt, wa.size()); end
  endtask
  task automatic test_stray_start();
    bit to;
    clear();
    run(5, 100, N, 0, 300, to);
    vectors++; if (to || wa.size() != N || seq_err(5) != 0) begin miscompares++; $display("FAIL stray_sequence got n=%0d err=%0d want %0d/0", wa.size(), seq_err(5), N); end
    vectors++; if (err_cnt != 0 || done_cnt != 1) begin miscompares++; $display("FAIL stray_status got err=%0d done=%0d want 0/1", err_cnt, done_cnt); end
  endtask
  task automatic test_reset_mid();
    bit to;
    clear();
    run(4, 100, 500, 0, -1, to);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.pix_ready_out, bus.bram_we_out, bus.bram_addr_out, bus.bram_din_out, bus.busy_out, bus.done_out, bus.error_out} !== 30'd0) begin
      miscompares++; $display("FAIL async_reset got ready=%b busy=%b addr=%0d want 0", bus.pix_ready_out, bus.busy_out, bus.bram_addr_out);
    end
    vectors++; if (wa.size() != 500) begin miscompares++; $display("FAIL abort_writes got %0d want 500", wa.size()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    clear();
    run(4, 100, N, 0, -1, to);
    vectors++; if (wa.size() == 0 || wa[0] !== 17'd114) begin miscompares++; $display("FAIL restart_first got size %0d want addr 114", wa.size()); end
    vectors++; if (to || wa.size() != N || seq_err(4) != 0 || done_cnt != 1) begin miscompares++; $display("FAIL restart_sequence got n=%0d err=%0d done=%0d want %0d/0/1", wa.size(), seq_err(4), done_cnt, N); end
  endtask
  initial begin
    bus.start_in = 1'b0; bus.letter_in = '0; bus.pix_data_in = '0; bus.pix_valid_in = 1'b0;
    clear();
    test_reset();
    test_letter1();
    test_back_to_back();
    test_valid_toggle();
    test_error();
    test_stray_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
